// File: rtl/dcache_nway_wb_if.sv
// CPU word port and L2 line port of the N-way write-back data cache.
// master = CPU/memory environment side, slave = the cache itself.
interface dcache_nway_wb_if #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int LINE_BITS = 128
);
  logic [ADDR_W-1:0]    mem_address;
  logic                 mem_read;
  logic                 mem_write;
  logic [DATA_W/8-1:0]  mem_byte_enable;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 mem_resp;
  logic [ADDR_W-1:0]    pmem_address;
  logic                 pmem_read;
  logic                 pmem_write;
  logic [LINE_BITS-1:0] pmem_rdata;
  logic [LINE_BITS-1:0] pmem_wdata;
  logic                 pmem_resp;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/dcache_nway_wb.sv
// N-way set-associative write-back/write-allocate L1 D-cache with tree pseudo-LRU.
// Optional macro DCACHE_PERF_CNT_EN adds hit/miss/writeback counter outputs.

// One way: valid/dirty/tag/line storage, combinational read, posedge write.
module dcache_way #(
  parameter int SETS      = 8,
  parameter int LINE_BITS = 128,
  parameter int TAG_W     = 9,
  parameter int DATA_W    = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [$clog2(SETS)-1:0]              idx,
  input  logic                                 fill_we,
  input  logic [TAG_W-1:0]                     fill_tag,
  input  logic [LINE_BITS-1:0]                 fill_line,
  input  logic                                 word_we,
  input  logic [$clog2(LINE_BITS/DATA_W)-1:0]  wsel,
  input  logic [DATA_W/8-1:0]                  be,
  input  logic [DATA_W-1:0]                    wdata,
  output logic                                 valid,
  output logic                                 dirty,
  output logic [TAG_W-1:0]                     tag,
  output logic [LINE_BITS-1:0]                 line
);
  localparam int BE_W = DATA_W/8;

  logic [SETS-1:0]      valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Reset takes priority so an aborted fill never lands in the array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_we) begin
        tag_q[idx]  <= fill_tag;
        data_q[idx] <= fill_line;
      end else if (word_we) begin
        for (int b = 0; b < BE_W; b++)
          if (be[b]) data_q[idx][int'(wsel)*DATA_W + b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign line  = data_q[idx];
endmodule

module dcache_nway_wb #(
  parameter int WAYS      = 2,
  parameter int SETS      = 8,
  parameter int LINE_BITS = 128,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  dcache_nway_wb_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count,
  output logic [31:0]     wb_count
`endif
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int OFF_W  = $clog2(LINE_BITS/8);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int BE_W   = DATA_W/8;
  localparam int WOFF_W = $clog2(BE_W);
  localparam int WSEL_W = OFF_W - WOFF_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int PL_W   = WAYS - 1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC} state_t;
  state_t state_q, state_d;

  logic [IDX_W-1:0]  req_idx, idx_q, arr_idx;
  logic [TAG_W-1:0]  req_tag, tag_q;
  logic [WSEL_W-1:0] req_wsel;
  logic              req, is_wr;
  logic              unused_byte_off;

  assign req_idx  = bus.mem_address[OFF_W +: IDX_W];
  assign req_tag  = bus.mem_address[ADDR_W-1 -: TAG_W];
  assign req_wsel = bus.mem_address[WOFF_W +: WSEL_W];
  assign req      = bus.mem_read | bus.mem_write;
  assign is_wr    = bus.mem_write;
  assign unused_byte_off = ^bus.mem_address[WOFF_W-1:0];

  // Line transactions use the set latched at miss time, so a dropped
  // request whose address moves cannot redirect the fill.
  assign arr_idx = (state_q == S_IDLE) ? req_idx : idx_q;

  logic [WAYS-1:0]                 way_valid, way_dirty, hit_vec, fill_we, word_we;
  logic [WAYS-1:0][TAG_W-1:0]      way_tag;
  logic [WAYS-1:0][LINE_BITS-1:0]  way_line;
  logic [WAY_W-1:0]                victim_q, victim_d, hit_way;
  logic                            hit, fill_en, word_en, plru_en, miss_start;
  logic [SETS-1:0][PL_W-1:0]       plru_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign hit_vec[w] = way_valid[w] && (way_tag[w] == req_tag);
    assign fill_we[w] = fill_en && (victim_q == WAY_W'(w));
    assign word_we[w] = word_en && hit_vec[w];

    dcache_way #(
      .SETS(SETS), .LINE_BITS(LINE_BITS), .TAG_W(TAG_W), .DATA_W(DATA_W)
    ) u_way (
      .clk      (clk),
      .reset    (reset),
      .idx      (arr_idx),
      .fill_we  (fill_we[w]),
      .fill_tag (tag_q),
      .fill_line(bus.pmem_rdata),
      .word_we  (word_we[w]),
      .wsel     (req_wsel),
      .be       (bus.mem_byte_enable),
      .wdata    (bus.mem_wdata),
      .valid    (way_valid[w]),
      .dirty    (way_dirty[w]),
      .tag      (way_tag[w]),
      .line     (way_line[w])
    );
  end

  assign hit = |hit_vec;

  always_comb begin
    hit_way       = '0;
    bus.mem_rdata = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) begin
        hit_way       = WAY_W'(w);
        bus.mem_rdata = way_line[w][int'(req_wsel)*DATA_W +: DATA_W];
      end
  end

  // Tree walk from root (node 0, children 2n+1/2n+2); bit=1 -> upper half.
  function automatic logic [WAY_W-1:0] plru_pick(input logic [PL_W-1:0] t);
    int               node;
    logic [WAY_W-1:0] v;
    node = 0;
    v    = '0;
    for (int l = 0; l < WAY_W; l++) begin
      v[WAY_W-1-l] = t[node];
      node = 2*node + 1 + int'(t[node]);
    end
    return v;
  endfunction

  function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] t,
                                                 input logic [WAY_W-1:0] w);
    int              node;
    logic [PL_W-1:0] r;
    node = 0;
    r    = t;
    for (int l = 0; l < WAY_W; l++) begin
      r[node] = ~w[WAY_W-1-l];
      node = 2*node + 1 + int'(w[WAY_W-1-l]);
    end
    return r;
  endfunction

  always_comb begin
    victim_d = plru_pick(plru_q[req_idx]);
    for (int w = WAYS-1; w >= 0; w--)
      if (!way_valid[w]) victim_d = WAY_W'(w);
  end

  always_comb begin
    state_d          = state_q;
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = way_line[victim_q];
    fill_en          = 1'b0;
    word_en          = 1'b0;
    plru_en          = 1'b0;
    miss_start       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            bus.mem_resp = 1'b1;
            plru_en      = 1'b1;
            word_en      = is_wr;
          end else begin
            miss_start = 1'b1;
            state_d    = (way_valid[victim_d] && way_dirty[victim_d]) ? S_WB : S_ALLOC;
          end
        end
      end
      S_WB: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {way_tag[victim_q], idx_q, {OFF_W{1'b0}}};
        if (bus.pmem_resp) state_d = S_ALLOC;
      end
      S_ALLOC: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {tag_q, idx_q, {OFF_W{1'b0}}};
        if (bus.pmem_resp) begin
          fill_en = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      plru_q   <= '0;
      victim_q <= '0;
      idx_q    <= '0;
      tag_q    <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        victim_q <= victim_d;
        idx_q    <= req_idx;
        tag_q    <= req_tag;
      end
      if (plru_en) plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // missed_q marks a request already counted as a miss, so its final
  // post-fill hit does not also count as a hit.
  logic missed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
      missed_q   <= 1'b0;
    end else begin
      if (miss_start) begin
        miss_count <= miss_count + 32'd1;
        missed_q   <= 1'b1;
      end else if (bus.mem_resp) begin
        if (!missed_q) hit_count <= hit_count + 32'd1;
        missed_q <= 1'b0;
      end else if (state_q == S_IDLE && !req) begin
        missed_q <= 1'b0;
      end
      if (state_q == S_WB && bus.pmem_resp) wb_count <= wb_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_nway_wb.sv
// Randomized self-checking bench for dcache_nway_wb (WAYS=4) against a
// behavioural cache + backing-memory model; honours DCACHE_PERF_CNT_EN.
module tb_dcache_nway_wb;
  localparam int WAYS = 4, SETS = 8, LINE_BITS = 128, ADDR_W = 16, DATA_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_nway_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BITS(LINE_BITS)) bus();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  dcache_nway_wb #(
    .WAYS(WAYS), .SETS(SETS), .LINE_BITS(LINE_BITS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count),
    .wb_count  (wb_count)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: cache contents per set/way, tree-PLRU bits, memory.
  bit                   m_valid [SETS][WAYS];
  bit                   m_dirty [SETS][WAYS];
  int                   m_tag   [SETS][WAYS];
  logic [LINE_BITS-1:0] m_data  [SETS][WAYS];
  bit                   m_plru  [SETS][WAYS-1];
  logic [LINE_BITS-1:0] bmem    [int];
  int                   e_hit, e_miss, e_wb;

  function automatic logic [LINE_BITS-1:0] line_of(input int la);
    if (!bmem.exists(la)) bmem[la] = {$urandom, $urandom, $urandom, $urandom};
    return bmem[la];
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
      for (int n = 0; n < WAYS-1; n++) m_plru[s][n] = 0;
    end
    e_hit = 0; e_miss = 0; e_wb = 0;
  endfunction

  // Victim search by halving the way range [lo, lo+n).
  function automatic int plru_victim(input int s);
    int lo = 0, n = WAYS, node = 0;
    while (n > 1) begin
      n = n / 2;
      if (m_plru[s][node]) begin lo += n; node = 2*node + 2; end
      else node = 2*node + 1;
    end
    return lo;
  endfunction

  function automatic void plru_use(input int s, input int way);
    int lo = 0, n = WAYS, node = 0;
    while (n > 1) begin
      n = n / 2;
      if (way >= lo + n) begin m_plru[s][node] = 0; lo += n; node = 2*node + 2; end
      else begin m_plru[s][node] = 1; node = 2*node + 1; end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_address = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_byte_enable = '0; bus.mem_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One CPU request with a bench-side memory responder; checks latency,
  // line traffic and read data against the model, then updates the model.
  task automatic access(input logic [15:0] addr, input bit rd, input bit wr,
                        input logic [1:0] be, input logic [15:0] wd,
                        input bit drop_in, output logic [15:0] rdata_o);
    int idx, tag, wsel, way, lat, exp_cyc, cyc_resp, wait_c, wb_addr, fill_addr;
    int got_wb = -1, got_fill = -1, wb_at = -1, fill_at = -1;
    bit hit, wb, done, drop;
    logic [LINE_BITS-1:0] wb_line, got_wb_line, fl;
    logic [15:0] exp_rd;
    idx  = int'(addr[6:4]);
    tag  = int'(addr[15:7]);
    wsel = int'(addr[3:1]);
    hit = 0; way = 0; wb = 0; wb_addr = -1; fill_addr = -1; wb_line = '0;
    for (int i = 0; i < WAYS; i++)
      if (m_valid[idx][i] && m_tag[idx][i] == tag) begin hit = 1; way = i; end
    if (!hit) begin
      way = -1;
      for (int i = WAYS-1; i >= 0; i--) if (!m_valid[idx][i]) way = i;
      if (way < 0) way = plru_victim(idx);
      wb = m_valid[idx][way] && m_dirty[idx][way];
      if (wb) begin
        wb_addr = (m_tag[idx][way] << 7) | (idx << 4);
        wb_line = m_data[idx][way];
      end
      fill_addr = int'(addr) & 32'hFFF0;
      fl = line_of(fill_addr);
      exp_rd = fl[wsel*16 +: 16];
    end else exp_rd = m_data[idx][way][wsel*16 +: 16];
    drop    = drop_in && !hit;
    lat     = $urandom_range(0, 3);
    exp_cyc = hit ? 0 : ((wb ? lat + 1 : 0) + lat + 2);

    bus.mem_address = addr; bus.mem_read = rd; bus.mem_write = wr;
    bus.mem_byte_enable = be; bus.mem_wdata = wd;
    done = 0; cyc_resp = -1; wait_c = 0; rdata_o = '0; got_wb_line = '0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (bus.mem_resp) begin
        if (cyc_resp < 0) cyc_resp = c;
        rdata_o = bus.mem_rdata;
        if (!drop) done = 1;
      end
      if (drop && fill_at >= 0 && c == fill_at + 1) begin
        vectors++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
          errors++;
          $display("FAIL drop_idle_strobes addr=%h: got rd=%b wr=%b want 0 0", addr, bus.pmem_read, bus.pmem_write);
        end
        done = 1;
      end
      if (!done && (bus.pmem_read || bus.pmem_write)) begin
        if (drop) begin bus.mem_read = 1'b0; bus.mem_write = 1'b0; end
        if (wait_c == lat) begin
          wait_c = 0;
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) begin
            got_wb = int'(bus.pmem_address); got_wb_line = bus.pmem_wdata; wb_at = c;
            bmem[got_wb] = bus.pmem_wdata;
          end else begin
            got_fill = int'(bus.pmem_address); fill_at = c;
            bus.pmem_rdata = line_of(got_fill);
          end
        end else wait_c++;
      end
      @(negedge clk);
      bus.pmem_resp = 1'b0;
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;

    vectors++;
    if (cyc_resp !== (drop ? -1 : exp_cyc)) begin
      errors++;
      $display("FAIL resp_cycle addr=%h drop=%0d: got %0d want %0d", addr, drop, cyc_resp, drop ? -1 : exp_cyc);
    end
    vectors++;
    if (got_fill !== fill_addr) begin
      errors++;
      $display("FAIL fill_addr addr=%h: got %0h want %0h", addr, got_fill, fill_addr);
    end
    vectors++;
    if (got_wb !== wb_addr) begin
      errors++;
      $display("FAIL wb_addr addr=%h: got %0h want %0h", addr, got_wb, wb_addr);
    end
    if (wb) begin
      vectors++;
      if (got_wb_line !== wb_line || wb_at >= fill_at) begin
        errors++;
        $display("FAIL wb_data addr=%h: got %h at %0d want %h before fill at %0d", addr, got_wb_line, wb_at, wb_line, fill_at);
      end
    end
    if (rd && !wr && !drop) begin
      vectors++;
      if (rdata_o !== exp_rd) begin
        errors++;
        $display("FAIL rdata addr=%h: got %h want %h", addr, rdata_o, exp_rd);
      end
    end

    if (!hit) begin
      e_miss++;
      if (wb) e_wb++;
      m_valid[idx][way] = 1; m_dirty[idx][way] = 0;
      m_tag[idx][way] = tag; m_data[idx][way] = line_of(fill_addr);
    end else e_hit++;
    if (!drop) begin
      if (wr) begin
        for (int b = 0; b < 2; b++)
          if (be[b]) m_data[idx][way][wsel*16 + b*8 +: 8] = wd[b*8 +: 8];
        m_dirty[idx][way] = 1;
      end
      plru_use(idx, way);
    end
  endtask

  task automatic test_reset();
    logic [LINE_BITS-1:0] l;
    do_reset();
    bus.mem_address = 16'h0040;
    #1;
    vectors++;
    if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || bus.mem_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got resp=%b prd=%b pwr=%b rdata=%h want 0 0 0 0000",
               bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.mem_rdata);
    end
    @(negedge clk);
    l = {$urandom, $urandom, $urandom, $urandom};
    l[15:0] = 16'hBEEF; l[31:16] = 16'hCAFE;
    bmem[32'h0040] = l;
  endtask

  task automatic test_read_miss();
    logic [15:0] rd;
    access(16'h0040, 1, 0, 2'b00, 16'h0, 0, rd);
    vectors++;
    if (rd !== 16'hBEEF) begin errors++; $display("FAIL first_read: got %h want beef", rd); end
  endtask

  task automatic test_write_hit();
    logic [15:0] rd;
    access(16'h0042, 0, 1, 2'b01, 16'h1234, 0, rd);
    access(16'h0042, 1, 0, 2'b00, 16'h0, 0, rd);
    vectors++;
    if (rd !== 16'hCA34) begin errors++; $display("FAIL byte_merge: got %h want ca34", rd); end
  endtask

  // Fill tags 1..4 of set 0, dirty tag 4 (way 3), then touch ways 0,2,1:
  // tree PLRU now names way 3, so tag 5 must write back line 0x0200 first.
  task automatic test_plru_evict();
    logic [15:0] rd;
    do_reset();
    for (int t = 1; t <= 4; t++) access(16'(t << 7), 1, 0, 2'b00, 16'h0, 0, rd);
    access(16'h0200, 0, 1, 2'b11, 16'hA5C3, 0, rd);
    access(16'h0080, 1, 0, 2'b00, 16'h0, 0, rd);
    access(16'h0180, 1, 0, 2'b00, 16'h0, 0, rd);
    access(16'h0100, 1, 0, 2'b00, 16'h0, 0, rd);
    access(16'h0280, 1, 0, 2'b00, 16'h0, 0, rd);
    vectors++;
    if (bmem[32'h0200][15:0] !== 16'hA5C3) begin
      errors++;
      $display("FAIL wb_mem_word: got %h want a5c3", bmem[32'h0200][15:0]);
    end
    access(16'h0280, 1, 0, 2'b00, 16'h0, 0, rd);
  endtask

  task automatic test_rw_both();
    logic [15:0] rd;
    access(16'h0236, 1, 1, 2'b11, 16'h5A6B, 0, rd);
    access(16'h0236, 1, 0, 2'b00, 16'h0, 0, rd);
    vectors++;
    if (rd !== 16'h5A6B) begin errors++; $display("FAIL rw_both_is_write: got %h want 5a6b", rd); end
  endtask

  task automatic test_random();
    logic [15:0] rd, a;
    int op;
    for (int n = 0; n < 250; n++) begin
      a  = 16'(($urandom_range(0, 5) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 7) << 1));
      op = $urandom_range(0, 3);
      access(a, op != 1, op == 1 || op == 2, 2'($urandom_range(1, 3)), 16'($urandom),
             $urandom_range(0, 15) == 0, rd);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] rd;
    bit seen;
    do_reset();
    bus.mem_address = 16'h0040; bus.mem_read = 1'b1;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      #1;
      if (bus.pmem_read) seen = 1;
      else @(negedge clk);
    end
    vectors++;
    if (!seen) begin errors++; $display("FAIL abort_pmem_read: got 0 want 1"); end
    reset = 1'b1; bus.pmem_resp = 1'b1; bus.pmem_rdata = line_of(32'h0040);
    @(negedge clk);
    #1;
    vectors++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || bus.mem_resp !== 1'b0) begin
      errors++;
      $display("FAIL abort_strobes: got prd=%b pwr=%b resp=%b want 0 0 0", bus.pmem_read, bus.pmem_write, bus.mem_resp);
    end
    reset = 1'b0; bus.pmem_resp = 1'b0; bus.mem_read = 1'b0;
    model_reset();
    @(negedge clk);
    access(16'h0040, 1, 0, 2'b00, 16'h0, 0, rd);
  endtask

`ifdef DCACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    #1;
    vectors++;
    if (hit_count !== 32'(e_hit) || miss_count !== 32'(e_miss) || wb_count !== 32'(e_wb)) begin
      errors++;
      $display("FAIL perf_counts: got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
               hit_count, miss_count, wb_count, e_hit, e_miss, e_wb);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    reset = 1'b1;
    test_reset();
    test_read_miss();
    test_write_hit();
    test_plru_evict();
`ifdef DCACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    test_rw_both();
    test_random();
`ifdef DCACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    test_reset_abort();
`ifdef DCACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
